// File: rtl/muldiv_pkg.sv
// Shared op encoding and FSM state type for the iterative multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULU = 2'b00,
        OP_MUL  = 2'b01,
        OP_DIVU = 2'b10,
        OP_DIV  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MUL  = 2'b01,
        DIV  = 2'b10,
        DONE = 2'b11
    } state_e;

    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return op[0];
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative W-bit multiplier / restoring divider, one bit per cycle.
// Latency: result valid W cycles after accept (1 cycle for a zero divisor).
// Backpressure: result held in DONE until out_ready; in_ready only while IDLE.
module muldiv_iter
    import muldiv_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   op,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_lo,
    output logic [W-1:0] out_hi,
    output logic         div_by_zero
);

    localparam int CW = $clog2(W);

    state_e          state, state_nxt;
    logic [CW-1:0]   cnt;
    logic [W-1:0]    acc_hi, acc_lo, opnd;
    logic [W-1:0]    res_lo, res_hi;
    logic            neg_q, neg_r, dbz;

    logic            accept, last, div_zero;
    logic [W-1:0]    a_mag, b_mag;
    logic [W:0]      mul_sum, div_trial;
    logic            div_ge;
    logic [W-1:0]    mul_hi_nxt, mul_lo_nxt, div_hi_nxt, div_lo_nxt;
    logic [2*W-1:0]  prod_fix;
    logic [W-1:0]    q_fix, r_fix, dz_rem;

    assign accept   = in_valid && in_ready;
    assign last     = (cnt == CW'(W - 1));
    assign div_zero = (opnd == '0);

    // Signed ops run on magnitudes; the sign is restored when results load.
    assign a_mag = (op_is_signed(op) && in_a[W-1]) ? -in_a : in_a;
    assign b_mag = (op_is_signed(op) && in_b[W-1]) ? -in_b : in_b;

    // Shift-add step: acc_lo holds the multiplier and collects product low bits.
    assign mul_sum    = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    assign mul_hi_nxt = mul_sum[W:1];
    assign mul_lo_nxt = {mul_sum[0], acc_lo[W-1:1]};

    // Restoring step: acc_hi is the partial remainder, acc_lo shifts dividend out / quotient in.
    assign div_trial  = {acc_hi, acc_lo[W-1]} - {1'b0, opnd};
    assign div_ge     = ~div_trial[W];
    assign div_hi_nxt = div_ge ? div_trial[W-1:0] : {acc_hi[W-2:0], acc_lo[W-1]};
    assign div_lo_nxt = {acc_lo[W-2:0], div_ge};

    assign prod_fix = neg_q ? -{mul_hi_nxt, mul_lo_nxt} : {mul_hi_nxt, mul_lo_nxt};
    assign q_fix    = neg_q ? -div_lo_nxt : div_lo_nxt;
    assign r_fix    = neg_r ? -div_hi_nxt : div_hi_nxt;
    assign dz_rem   = neg_r ? -acc_lo : acc_lo;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = op_is_div(op) ? DIV : MUL;
            end
            MUL:  if (last) state_nxt = DONE;
            DIV:  if (div_zero || last) state_nxt = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            opnd   <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            res_lo <= '0;
            res_hi <= '0;
            dbz    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    cnt    <= '0;
                    acc_hi <= '0;
                    acc_lo <= op_is_div(op) ? a_mag : b_mag;
                    opnd   <= op_is_div(op) ? b_mag : a_mag;
                    neg_q  <= op_is_signed(op) && (in_a[W-1] ^ in_b[W-1]);
                    neg_r  <= op_is_signed(op) && in_a[W-1];
                end
                MUL: begin
                    cnt    <= cnt + CW'(1);
                    acc_hi <= mul_hi_nxt;
                    acc_lo <= mul_lo_nxt;
                    if (last) begin
                        res_hi <= prod_fix[2*W-1:W];
                        res_lo <= prod_fix[W-1:0];
                        dbz    <= 1'b0;
                    end
                end
                DIV: begin
                    if (div_zero) begin
                        res_lo <= '1;
                        res_hi <= dz_rem;
                        dbz    <= 1'b1;
                    end else begin
                        cnt    <= cnt + CW'(1);
                        acc_hi <= div_hi_nxt;
                        acc_lo <= div_lo_nxt;
                        if (last) begin
                            res_lo <= q_fix;
                            res_hi <= r_fix;
                            dbz    <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_lo      = res_lo;
    assign out_hi      = res_hi;
    assign div_by_zero = dbz;

endmodule

// File: tb/tb_muldiv_iter.sv
// Randomized and directed self-checking bench for muldiv_iter against an arithmetic reference model.
module tb_muldiv_iter;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   op;
    logic [W-1:0] in_a, in_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_lo, out_hi;
    logic         div_by_zero;

    int n_checks = 0;
    int n_errors = 0;

    muldiv_iter #(.W(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .op          (op),
        .in_a        (in_a),
        .in_b        (in_b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_lo      (out_lo),
        .out_hi      (out_hi),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic plus the zero-divisor and overflow rules.
    function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] lo, output logic [31:0] hi, output logic dz);
        longint unsigned ua, ub;
        longint          sa, sb;
        logic [63:0]     p, q, r;
        ua = 64'(a);
        ub = 64'(b);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        dz = 1'b0;
        lo = '0;
        hi = '0;
        case (o)
            2'b00: begin p = ua * ub; lo = p[31:0]; hi = p[63:32]; end
            2'b01: begin p = sa * sb; lo = p[31:0]; hi = p[63:32]; end
            default: begin
                if (b == 32'd0) begin
                    lo = 32'hFFFF_FFFF; hi = a; dz = 1'b1;
                end else if (o == 2'b10) begin
                    q = ua / ub; r = ua % ub; lo = q[31:0]; hi = r[31:0];
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    lo = 32'h8000_0000; hi = 32'd0;
                end else begin
                    q = sa / sb; r = sa % sb; lo = q[31:0]; hi = r[31:0];
                end
            end
        endcase
    endfunction

    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int hold, input bit noise);
        logic [31:0] elo, ehi;
        logic        edz;
        int          lat, exp_lat;
        model(o, a, b, elo, ehi, edz);
        exp_lat = (o[1] && b == 32'd0) ? 1 : W;
        check("in_ready_idle", 64'(in_ready), 64'd1);
        op = o; in_a = a; in_b = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            if (lat == 0) check("in_ready_busy", 64'(in_ready), 64'd0);
            if (noise) begin
                in_valid  = 1'($urandom_range(0, 1));
                op        = 2'($urandom_range(0, 3));
                in_a      = $urandom;
                in_b      = $urandom;
                out_ready = 1'($urandom_range(0, 1));
            end
            @(posedge clk); #1;
            lat++;
        end
        out_ready = 1'b0;
        check("latency", 64'(lat), 64'(exp_lat));
        check("out_lo", 64'(out_lo), 64'(elo));
        check("out_hi", 64'(out_hi), 64'(ehi));
        check("div_by_zero", 64'(div_by_zero), 64'(edz));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_lo", 64'(out_lo), 64'(elo));
            check("hold_hi", 64'(out_hi), 64'(ehi));
            check("hold_in_ready", 64'(in_ready), 64'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("valid_drop", 64'(out_valid), 64'd0);
        check("in_ready_back", 64'(in_ready), 64'd1);
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra, rb;
        int          sel;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = 2'b00; in_a = '0; in_b = '0;
        #12;
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_lo", 64'(out_lo), 64'd0);
        check("rst_hi", 64'(out_hi), 64'd0);
        check("rst_dbz", 64'(div_by_zero), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);

        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
        run_op(2'b01, 32'hFFFF_FFFD, 32'd5, 0, 1'b0);
        run_op(2'b11, 32'hFFFF_FFF9, 32'd2, 0, 1'b0);
        run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
        run_op(2'b10, 32'd100, 32'd0, 0, 1'b0);
        run_op(2'b11, 32'hFFFF_FF9C, 32'd0, 1, 1'b0);
        run_op(2'b10, 32'd100, 32'd7, 5, 1'b0);

        // Reset in the middle of a multiply: nothing of it may survive.
        op = 2'b00; in_a = 32'h1234_5678; in_b = 32'h9ABC_DEF0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 64'(out_valid), 64'd0);
        check("midrst_lo", 64'(out_lo), 64'd0);
        check("midrst_hi", 64'(out_hi), 64'd0);
        check("midrst_dbz", 64'(div_by_zero), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        run_op(2'b00, 32'd6, 32'd7, 0, 1'b0);

        for (int n = 0; n < 60; n++) begin
            ro  = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0) rb = 32'd0;
            if (sel == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            if (sel == 2) rb = 32'($urandom_range(1, 20));
            if (sel == 3) rb = -32'($urandom_range(1, 20));
            run_op(ro, ra, rb, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
